hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
// Pipeline hazard and stall controller for the 5-stage MIPS core. Consumes the staged control bits
// the controller emits (RegWrite/MemRead/MemWrite per stage, BranchD) plus register numbers. Drives
// forwarding selects, stall/flush for every pipeline register (FlushE feeds the controller's clear
// input), the data-memory request handshake, and a stall-cycle performance counter.
// PARAMETERS
// CNT_W    32  width of the StallCount performance counter (saturating)
// TIMEOUT  16  max cycles a data-memory request may wait in WAIT before the ERR state is entered
// PORTS
// clk         in   1      core clock, all state on rising edge
// rst         in   1      asynchronous, active-high reset
// RsD,RtD     in   5      source registers of the instruction in ID
// RsE,RtE     in   5      source registers of the instruction in EX
// WriteRegE   in   5      destination register in EX; WriteRegM (MEM) and WriteRegW (WB) are identical 5-bit inputs
// BranchD     in   1      branch resolved in ID
// RegWriteE   in   1      EX writes a register; RegWriteM and RegWriteW are the same bit in MEM and WB
// MemReadE    in   1      load in EX
// MemReadM    in   1      load in MEM; MemWriteM is the matching 1-bit store flag in MEM
// MemReadyM   in   1      data memory completes the access this cycle
// DMemReq     out  1      data-memory request, held until the MemReadyM cycle
// ForwardAE   out  2      EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
// ForwardBE   out  2      EX operand B select, same encoding
// ForwardAD   out  1      ID compare A takes the MEM result; ForwardBD is the same for compare B
// StallF      out  1      hold PC; StallD/StallE/StallM are 1-bit holds for IF/ID, ID/EX, EX/MEM
// FlushE      out  1      clear ID/EX (bubble), drives controller clear
// FlushW      out  1      clear MEM/WB (bubble)
// MemErr      out  1      sticky memory-timeout error
// StallCount  out  CNT_W  count of cycles with StallF=1
// BEHAVIOUR
// - Reset: FSM=IDLE, wait counter=0, StallCount=0, MemErr=0. All Stall*/Flush*/DMemReq are forced 0 while rst=1.
// - Register 0 never matches in any forward or stall compare.
// - ForwardAE=10 if RegWriteM & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW==RsE; else 00. MEM wins. BE uses RtE.
// - ForwardAD = RegWriteM & WriteRegM==RsD. ForwardBD uses RtD. Outputs are combinational, 0 latency.
// - lwstall = MemReadE & (WriteRegE==RsD | WriteRegE==RtD).
// - brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemReadM & WriteRegM∈{RsD,RtD})).
// - FSM states and transitions:
//     IDLE: acc=MemReadM|MemWriteM. DMemReq=acc. If acc & ~MemReadyM -> WAIT and clear wcnt; otherwise stay in IDLE.
//     WAIT: DMemReq=1. On MemReadyM -> IDLE. Otherwise wcnt++. If wcnt==TIMEOUT-1 with no ready -> ERR.
//     ERR: DMemReq=0 and MemErr=1; the FSM leaves ERR only on reset.
// - memstall = (DMemReq & ~MemReadyM) | (state==ERR).
// - Priority, applied combinationally:
//     memstall: StallF=StallD=StallE=StallM=1, FlushE=0, FlushW=1 (WB sees a bubble, no double write).
//     else lwstall|brstall: StallF=StallD=1, FlushE=1, StallE=StallM=FlushW=0.
//     else: all 0.
// - A MemReadyM arriving in the same cycle as the request (IDLE) costs 0 stall cycles.
// - MemReadyM is ignored while DMemReq=0.
// - StallCount increments on every cycle with StallF=1 and saturates at 2^CNT_W-1.
// - Reset asserted mid-WAIT aborts the request: DMemReq drops immediately (asynchronous).
// TESTING
// - Forwarding: RegWriteM=1,WriteRegM=8,RegWriteW=1,WriteRegW=8,RsE=8 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RsE=0 -> 00.
// - Load-use: MemReadE=1,WriteRegE=9,RtD=9 -> StallF=StallD=FlushE=1 for 1 cycle. With WriteRegE=0 -> no stall.
// - Branch: BranchD=1,RegWriteE=1,WriteRegE=4,RsD=4 -> stall+FlushE. Next cycle MEM-stage ALU result: ForwardAD=1, no stall.
// - Mem wait: MemReadM=1, MemReadyM low 3 cycles then high -> DMemReq high 4 cycles; StallF..StallM=1 and FlushW=1 for 3 cycles; StallCount=3.
// - Timeout at TIMEOUT=4: MemWriteM=1 with MemReadyM never set -> ERR entered, MemErr=1, all stalls held. rst pulse -> IDLE, MemErr=0, StallCount=0.
// - Overlap: memstall with lwstall in the same cycle -> FlushE=0, StallE=1. Async rst mid-WAIT -> DMemReq=0 before the next edge.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
// Also sequences the data-memory request handshake and counts stalled fetch cycles.
module hazard_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             BranchD,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReadE,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             MemReadyM,
    output logic             DMemReq,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_acc;
    logic w_lwstall;
    logic w_brstall;
    logic w_memstall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && reg_hit(WriteRegM, src)) begin
            return 2'b10;
        end else if (RegWriteW && reg_hit(WriteRegW, src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign w_acc = MemReadM | MemWriteM;

    // Forwarding selects and hazard detection.
    always_comb begin
        ForwardAE = fwd_sel(RsE);
        ForwardBE = fwd_sel(RtE);
        ForwardAD = RegWriteM && reg_hit(WriteRegM, RsD);
        ForwardBD = RegWriteM && reg_hit(WriteRegM, RtD);
        w_lwstall = MemReadE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD));
        w_brstall = BranchD &&
                    ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                     (MemReadM  && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));
    end

    // Memory request, stall/flush priority; everything held low during reset.
    always_comb begin
        DMemReq = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        case (r_state)
            S_IDLE:  DMemReq = w_acc;
            S_WAIT:  DMemReq = 1'b1;
            S_ERR:   DMemReq = 1'b0;
            default: DMemReq = 1'b0;
        endcase
        if (rst) begin
            DMemReq = 1'b0;
        end else begin
            DMemReq = DMemReq;
        end
        w_memstall = !rst && ((DMemReq && !MemReadyM) || (r_state == S_ERR));
        if (rst) begin
            StallF = 1'b0;
        end else if (w_memstall) begin
            // Whole pipe freezes; WB gets a bubble so the held MEM/WB entry is not written twice.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = 1'b0;
        end
    end

    assign MemErr     = (r_state == S_ERR);
    assign StallCount = r_stall_cnt;

    // Memory handshake FSM with timeout watchdog; ERR is left only through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && !MemReadyM) begin
                        r_state <= S_WAIT;
                        r_wcnt  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (MemReadyM) begin
                        r_state <= S_IDLE;
                    end else if (r_wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (StallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the forwarding, stall and memory rules.
module tb_hazard_unit;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, MemWriteM, MemReadyM;
    logic DMemReq, ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: request outstanding, cycles waited, error latched, stall cycles seen.
    bit m_busy;
    int m_wait;
    bit m_err;
    int m_cnt;

    logic [13:0] obs;
    logic [13:0] e;

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .BranchD(BranchD), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemReadyM(MemReadyM),
        .DMemReq(DMemReq), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    assign obs = {DMemReq, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
                  StallF, StallD, StallE, StallM, FlushE, FlushW, MemErr};

    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        if (RegWriteM && hit(WriteRegM, src)) return 2'b10;
        if (RegWriteW && hit(WriteRegW, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic req, mst, lw, br, fe, fw;
        logic [3:0] st;
        req = rst ? 1'b0 : (m_err ? 1'b0 : (m_busy ? 1'b1 : (MemReadM | MemWriteM)));
        mst = !rst && ((req && !MemReadyM) || m_err);
        lw  = MemReadE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD));
        br  = BranchD && ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                          (MemReadM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
        st = 4'b0000; fe = 1'b0; fw = 1'b0;
        if (rst) begin
            st = 4'b0000;
        end else if (mst) begin
            st = 4'b1111; fw = 1'b1;
        end else if (lw || br) begin
            st = 4'b1100; fe = 1'b1;
        end
        return {req, fsel(RsE), fsel(RtE),
                RegWriteM && hit(WriteRegM, RsD), RegWriteM && hit(WriteRegM, RtD),
                st, fe, fw, m_err};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_wait = 0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {BranchD, RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, MemWriteM, MemReadyM} = '0;
    endtask

    // Advance one clock, updating the model from the inputs that were present before the edge.
    task automatic tick();
        logic [13:0] pre;
        pre = exp_vec();
        @(posedge clk);
        if (!rst) begin
            if (pre[6] && m_cnt < CNT_MAX) m_cnt++;
            if (!m_err) begin
                if (m_busy) begin
                    if (MemReadyM) m_busy = 1'b0;
                    else if (m_wait == TIMEOUT - 1) begin m_err = 1'b1; m_busy = 1'b0; end
                    else m_wait++;
                end else if ((MemReadM || MemWriteM) && !MemReadyM) begin
                    m_busy = 1'b1; m_wait = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        clear_inputs();
        #1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset(); clear_inputs();
        MemReadM = 1'b1; RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3;
        #2;
        e = exp_vec();
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, e); end
        n_tests++;
        if ({DMemReq, StallF, FlushW, MemErr} !== 4'b0000 || StallCount !== 8'd0) begin
            n_fail++; $display("FAIL reset_state: got req/stf/flw/err=%b cnt=%0d expected 0000 cnt=0",
                               {DMemReq, StallF, FlushW, MemErr}, StallCount);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8; RtE = 5'd8;
        #1;
        n_tests++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_mem_wins: got AE=%b BE=%b expected 10 10", ForwardAE, ForwardBE);
        end
        RegWriteM = 1'b0;
        #1;
        n_tests++;
        if (ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_wb: got %b expected 01", ForwardAE); end
        RsE = 5'd0; RegWriteW = 1'b1; WriteRegW = 5'd0;
        #1;
        n_tests++;
        if (ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_r0: got %b expected 00", ForwardAE); end
        RegWriteM = 1'b1; WriteRegM = 5'd7; RsD = 5'd7; RtD = 5'd2; RsE = 5'd2; RegWriteW = 1'b1; WriteRegW = 5'd2;
        #1;
        e = exp_vec();
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_mixed: got %b expected %b", obs, e); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemReadE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        #1;
        n_tests++;
        if ({StallF, StallD, StallE, StallM, FlushE, FlushW} !== 6'b110010) begin
            n_fail++; $display("FAIL load_use: got %b expected 110010",
                               {StallF, StallD, StallE, StallM, FlushE, FlushW});
        end
        tick();
        WriteRegE = 5'd0; RtD = 5'd0;
        #1;
        n_tests++;
        if ({StallF, FlushE} !== 2'b00) begin
            n_fail++; $display("FAIL load_use_r0: got %b expected 00", {StallF, FlushE});
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd4; RsD = 5'd4;
        #1;
        n_tests++;
        if ({StallF, StallD, FlushE, ForwardAD} !== 4'b1110) begin
            n_fail++; $display("FAIL branch_stall: got %b expected 1110", {StallF, StallD, FlushE, ForwardAD});
        end
        tick();
        RegWriteE = 1'b0; WriteRegE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd4;
        #1;
        n_tests++;
        if ({StallF, FlushE, ForwardAD} !== 3'b001) begin
            n_fail++; $display("FAIL branch_fwd: got %b expected 001", {StallF, FlushE, ForwardAD});
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReadM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({DMemReq, StallF, StallD, StallE, StallM, FlushE, FlushW} !== 7'b1111101) begin
                n_fail++; $display("FAIL mem_wait_c%0d: got %b expected 1111101", i,
                                   {DMemReq, StallF, StallD, StallE, StallM, FlushE, FlushW});
            end
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        n_tests++;
        if ({DMemReq, StallF, FlushW} !== 3'b100) begin
            n_fail++; $display("FAIL mem_ready: got %b expected 100", {DMemReq, StallF, FlushW});
        end
        tick();
        MemReadM = 1'b0; MemReadyM = 1'b0;
        #1;
        n_tests++;
        if (StallCount !== 8'd3 || DMemReq !== 1'b0) begin
            n_fail++; $display("FAIL mem_count: got cnt=%0d req=%b expected cnt=3 req=0", StallCount, DMemReq);
        end
        // Same-cycle ready costs nothing.
        MemWriteM = 1'b1; MemReadyM = 1'b1;
        #1;
        n_tests++;
        if ({DMemReq, StallF} !== 2'b10) begin
            n_fail++; $display("FAIL mem_zero_wait: got %b expected 10", {DMemReq, StallF});
        end
        tick();
        MemWriteM = 1'b0; MemReadyM = 1'b0;
        #1;
        n_tests++;
        if (StallCount !== 8'd3) begin n_fail++; $display("FAIL mem_zero_cnt: got %0d expected 3", StallCount); end
    endtask

    task automatic test_timeout();
        do_reset();
        MemWriteM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < TIMEOUT + 3; i++) begin
            #1;
            e = exp_vec();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL timeout_c%0d: got %b expected %b", i, obs, e); end
            tick();
        end
        MemWriteM = 1'b0; MemReadyM = 1'b1;
        #1;
        n_tests++;
        if ({MemErr, DMemReq, StallF, StallD, StallE, StallM, FlushE, FlushW} !== 8'b10111101) begin
            n_fail++; $display("FAIL timeout_err: got %b expected 10111101",
                               {MemErr, DMemReq, StallF, StallD, StallE, StallM, FlushE, FlushW});
        end
        tick();
        do_reset();
        n_tests++;
        if (MemErr !== 1'b0 || StallCount !== 8'd0) begin
            n_fail++; $display("FAIL timeout_clear: got err=%b cnt=%0d expected err=0 cnt=0", MemErr, StallCount);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        MemReadM = 1'b1; MemReadyM = 1'b0; MemReadE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5;
        #1;
        n_tests++;
        if ({FlushE, StallE, FlushW} !== 3'b011) begin
            n_fail++; $display("FAIL overlap_prio: got %b expected 011", {FlushE, StallE, FlushW});
        end
        tick();
        #1;
        rst = 1'b1; model_reset();
        #1;
        n_tests++;
        if ({DMemReq, StallF, MemErr} !== 3'b000) begin
            n_fail++; $display("FAIL async_rst: got %b expected 000", {DMemReq, StallF, MemErr});
        end
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        MemWriteM = 1'b1;
        for (int i = 0; i < CNT_MAX + 40; i++) tick();
        n_tests++;
        if (StallCount !== 8'd255 || m_cnt != CNT_MAX) begin
            n_fail++; $display("FAIL saturate: got %0d expected 255", StallCount);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
            if (rst) rst = 1'b0;
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            BranchD = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            MemReadE = 1'($urandom_range(0, 1));
            MemReadM = ($urandom_range(0, 3) == 0); MemWriteM = ($urandom_range(0, 4) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 79) == 0) begin rst = 1'b1; model_reset(); end
            #1;
            e = exp_vec();
            n_tests++;
            if (obs !== e || StallCount !== 8'(m_cnt)) begin
                n_fail++; $display("FAIL random_%0d: got %b cnt=%0d expected %b cnt=%0d",
                                   i, obs, StallCount, e, m_cnt);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_overlap();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
